// File: rtl/lsu_mmio_if.sv
// Core-side LSU request/response bundle plus the UART transmit side-band.
// slave = lsu_mmio, master = core/UART environment driving requests.
interface lsu_mmio_if;
    logic        valid;
    logic        is_load;
    logic        is_store;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        uart_busy;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misalign;
    logic        uart_we;
    logic [7:0]  uart_data;

    modport slave (
        input  valid, is_load, is_store, size, unsigned_ld,
        input  addr, write_data, uart_busy,
        output stall, load_valid, load_data, misalign,
        output uart_we, uart_data
    );

    modport master (
        output valid, is_load, is_store, size, unsigned_ld,
        output addr, write_data, uart_busy,
        input  stall, load_valid, load_data, misalign,
        input  uart_we, uart_data
    );
endinterface

// File: rtl/lsu_mmio.sv
// LSU with word-organised data memory, UART TX queue and cycle-counter MMIO.
// Define LSU_MISALIGN_TRAP_EN to flag and suppress misaligned accesses.
module lsu_mmio #(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned TXQ_DEPTH  = 8,
    parameter logic [31:0] UART_ADDR  = 32'hF6FF_F070,
    parameter logic [31:0] HWCNT_ADDR = 32'hFFFF_FF00
) (
    input logic        clk,
    input logic        reset,
    lsu_mmio_if.slave  bus
);
    localparam int unsigned PW = $clog2(TXQ_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]       mem [2**ADDR_W];
    logic [7:0]        txq [TXQ_DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       hwcnt_q;
    logic              load_valid_q;
    logic [31:0]       load_data_q;

    logic              is_uart, is_hwcnt, is_mmio;
    logic              q_full, q_empty;
    logic              mis, accept, push, pop;
    logic              ld_go, st_mem;
    logic              sz_b, sz_h;
    logic [ADDR_W-1:0] widx;
    logic [3:0]        be;
    logic [31:0]       wlanes;
    logic [31:0]       rword;
    logic [31:0]       lval;
    logic [7:0]        rb;
    logic [15:0]       rh;

    assign is_uart  = bus.addr == UART_ADDR;
    assign is_hwcnt = bus.addr == HWCNT_ADDR;
    assign is_mmio  = is_uart | is_hwcnt;
    assign q_full   = cnt_q == CW'(TXQ_DEPTH);
    assign q_empty  = cnt_q == '0;
    assign sz_b     = bus.size == 2'b00;
    assign sz_h     = bus.size == 2'b01;

    // A full queue stalls even when a pop frees a slot this cycle.
    assign bus.stall = bus.valid & bus.is_store & is_uart & q_full;
    assign accept    = bus.valid & ~bus.stall & (bus.is_load | bus.is_store);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = ~reset & bus.valid & (bus.is_load | bus.is_store) & ~is_mmio
               & ((sz_h & bus.addr[0])
               | (bus.size[1] & (bus.addr[1:0] != 2'b00)));
`else
    assign mis = 1'b0;
`endif
    assign bus.misalign = mis;

    assign widx   = bus.addr[ADDR_W+1:2];
    assign rword  = mem[widx];
    assign st_mem = accept & bus.is_store & ~is_mmio & ~mis & ~reset;
    assign ld_go  = accept & bus.is_load & ~mis;
    assign push   = accept & bus.is_store & is_uart;
    assign pop    = ~q_empty & ~bus.uart_busy;

    assign rb = rword[{bus.addr[1:0], 3'b000} +: 8];
    assign rh = rword[{bus.addr[1], 4'b0000} +: 16];

    always_comb begin
        be     = 4'b1111;
        wlanes = bus.write_data;
        lval   = rword;
        unique case (1'b1)
            sz_b: begin
                be     = 4'b0001 << bus.addr[1:0];
                wlanes = {4{bus.write_data[7:0]}};
                lval   = {{24{~bus.unsigned_ld & rb[7]}}, rb};
            end
            sz_h: begin
                be     = bus.addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{bus.write_data[15:0]}};
                lval   = {{16{~bus.unsigned_ld & rh[15]}}, rh};
            end
            default: ;
        endcase
        if (is_hwcnt) begin
            lval = hwcnt_q;
        end else if (is_uart) begin
            lval = {23'b0, q_full, 8'(cnt_q)};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (st_mem) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) txq[wr_ptr_q] <= bus.write_data[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            hwcnt_q      <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            hwcnt_q      <= hwcnt_q + 32'd1;
            load_valid_q <= ld_go;
            if (ld_go) load_data_q <= lval;
        end
    end

    assign bus.load_valid = load_valid_q;
    assign bus.load_data  = load_data_q;
    assign bus.uart_we    = pop;
    assign bus.uart_data  = txq[rd_ptr_q];
endmodule

// File: tb/tb_lsu_mmio.sv
// Randomised bench for lsu_mmio against a byte-level memory/queue model.
// Directed literal checks pin the model on the main corner cases.
`timescale 1ns/1ps
module tb_lsu_mmio;
    localparam int          ADDR_W = 15;
    localparam int          DEPTH  = 8;
    localparam logic [31:0] UART   = 32'hF6FF_F070;
    localparam logic [31:0] HWCNT  = 32'hFFFF_FF00;

    logic clk = 1'b0;
    logic reset = 1'b0;

    lsu_mmio_if bus();

    lsu_mmio #(
        .ADDR_W(ADDR_W),
        .TXQ_DEPTH(DEPTH),
        .UART_ADDR(UART),
        .HWCNT_ADDR(HWCNT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mm [int];
    logic [7:0]  q [$];
    logic [7:0]  sent [$];
    logic [31:0] m_cnt = 0;
    logic [31:0] m_ld = 0;
    bit          m_lv = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // Reference model: checks outputs, then advances to the next edge.
    always @(negedge clk) begin
        logic [31:0] a, v, base, msk;
        int          n, w, l0;
        bit          mmio, stl, mis, popx, acc;
        if (reset) begin
            chk("rst_load_valid", bus.load_valid, 0);
            chk("rst_load_data", bus.load_data, 0);
            chk("rst_uart_we", bus.uart_we, 0);
            q.delete();
            m_cnt = 0;
            m_lv  = 0;
            m_ld  = 0;
        end else begin
            a    = bus.addr;
            n    = nbytes(bus.size);
            mmio = (a == UART) || (a == HWCNT);
            stl  = bus.valid && bus.is_store && a == UART && q.size() == DEPTH;
`ifdef LSU_MISALIGN_TRAP_EN
            mis  = bus.valid && (bus.is_load || bus.is_store) && !mmio
                   && (a % n != 0);
            base = a;
`else
            mis  = 0;
            base = a - (a % n);
`endif
            chk("stall", bus.stall, stl);
            chk("misalign", bus.misalign, mis);
            chk("load_valid", bus.load_valid, m_lv);
            chk("load_data", bus.load_data, m_ld);
            popx = q.size() > 0 && !bus.uart_busy;
            chk("uart_we", bus.uart_we, popx);
            if (popx) chk("uart_data", bus.uart_data, q[0]);
            if (bus.uart_we) sent.push_back(bus.uart_data);

            acc  = bus.valid && !stl && (bus.is_load || bus.is_store);
            w    = int'((base >> 2) % (1 << ADDR_W));
            l0   = int'(base % 4);
            m_lv = 0;
            if (acc && !mis && bus.is_load) begin
                m_lv = 1;
                if (a == HWCNT) begin
                    m_ld = m_cnt;
                end else if (a == UART) begin
                    m_ld = (q.size() == DEPTH ? 32'h100 : 32'h0) + q.size();
                end else begin
                    v = 0;
                    for (int i = 0; i < n; i++)
                        v = v | (32'(mm[w*4 + l0 + i]) << (8*i));
                    if (n < 4 && !bus.unsigned_ld && v[8*n-1]) begin
                        msk = 32'hFFFF_FFFF << (8*n);
                        v = v | msk;
                    end
                    m_ld = v;
                end
            end
            if (acc && !mis && bus.is_store && !mmio) begin
                for (int i = 0; i < n; i++)
                    mm[w*4 + l0 + i] = 8'(bus.write_data >> (8*i));
            end
            if (popx) void'(q.pop_front());
            if (acc && bus.is_store && a == UART)
                q.push_back(bus.write_data[7:0]);
            m_cnt = m_cnt + 1;
        end
    end

    task automatic idle();
        bus.valid       = 0;
        bus.is_load     = 0;
        bus.is_store    = 0;
        bus.size        = 0;
        bus.unsigned_ld = 0;
        bus.addr        = 0;
        bus.write_data  = 0;
    endtask

    task automatic setreq(input bit ld, input logic [1:0] sz,
                          input bit uns, input logic [31:0] a,
                          input logic [31:0] wd);
        bus.valid       = 1;
        bus.is_load     = ld;
        bus.is_store    = !ld;
        bus.size        = sz;
        bus.unsigned_ld = uns;
        bus.addr        = a;
        bus.write_data  = wd;
    endtask

    task automatic req(input bit ld, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
        setreq(ld, sz, uns, a, wd);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        logic [31:0] a;
        bit          blk;
        idle();
        bus.uart_busy = 0;
        #1 reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_lv", bus.load_valid, 0);
        chk("reset_ld", bus.load_data, 0);
        chk("reset_we", bus.uart_we, 0);
        chk("reset_mis", bus.misalign, 0);
        chk("reset_stall", bus.stall, 0);
        reset = 0;

        repeat (5) @(posedge clk);
        #1;
        req(1, 2'd2, 0, HWCNT, 0);
        chk("hwcnt_5", bus.load_data, 5);
        chk("hwcnt_lv", bus.load_valid, 1);

        for (int i = 0; i < 16; i++) req(0, 2'd2, 0, 32'(i*4), $urandom);

        req(0, 2'd2, 0, 32'h10, 32'hDEAD_BEEF);
        req(1, 2'd0, 0, 32'h13, 0);
        chk("ldb_signed", bus.load_data, 32'hFFFF_FFDE);
        req(1, 2'd0, 1, 32'h13, 0);
        chk("ldb_unsigned", bus.load_data, 32'h0000_00DE);

        req(0, 2'd2, 0, 32'h20, 0);
        req(0, 2'd1, 0, 32'h22, 32'h0000_A5A5);
        req(1, 2'd2, 0, 32'h20, 0);
        chk("raw_half_word", bus.load_data, 32'hA5A5_0000);
        req(1, 2'd1, 0, 32'h22, 0);
        chk("ldh_signed", bus.load_data, 32'hFFFF_A5A5);

        req(0, 2'd2, 0, 32'h40, 32'h1111_1111);
        setreq(0, 2'd2, 0, 32'h41, 32'h2222_2222);
        #1;
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_flag", bus.misalign, 1);
`else
        chk("mis_flag", bus.misalign, 0);
`endif
        @(posedge clk);
        #1;
        idle();
        req(1, 2'd2, 0, 32'h40, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_word", bus.load_data, 32'h1111_1111);
`else
        chk("mis_word", bus.load_data, 32'h2222_2222);
`endif

        sent.delete();
        bus.uart_busy = 1;
        for (int i = 0; i < 8; i++) req(0, 2'd0, 0, UART, 32'h41 + i);
        req(1, 2'd2, 0, UART, 0);
        chk("uart_status_full", bus.load_data, 32'h108);
        setreq(0, 2'd0, 0, UART, 32'h49);
        #1;
        chk("stall_full", bus.stall, 1);
        bus.uart_busy = 0;
        #1;
        chk("stall_no_pass", bus.stall, 1);
        @(posedge clk);
        #1;
        chk("stall_release", bus.stall, 0);
        @(posedge clk);
        #1;
        idle();
        repeat (12) @(posedge clk);
        #1;
        chk("uart_count", sent.size(), 9);
        for (int i = 0; i < 9 && i < sent.size(); i++)
            chk("uart_order", sent[i], 32'h41 + i);

        bus.uart_busy = 1;
        for (int i = 0; i < 3; i++) req(0, 2'd0, 0, UART, 32'h61 + i);
        req(1, 2'd2, 0, UART, 0);
        chk("uart_status_3", bus.load_data, 3);
        setreq(1, 2'd2, 0, 32'h10, 0);
        @(posedge clk);
        #1;
        idle();
        bus.uart_busy = 0;
        #1;
        reset = 1;
        #1;
        chk("midrst_we", bus.uart_we, 0);
        chk("midrst_lv", bus.load_valid, 0);
        chk("midrst_ld", bus.load_data, 0);
        repeat (2) @(posedge clk);
        #1;
        sent.delete();
        reset = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_tx", sent.size(), 0);

        for (int i = 0; i < 16; i++) req(0, 2'd2, 0, 32'(i*4), $urandom);
        for (int c = 0; c < 3000; c++) begin
            blk = ((c / 50) % 2) == 1;
            if (blk) bus.uart_busy = $urandom_range(0, 7) != 0;
            else     bus.uart_busy = $urandom_range(0, 3) == 0;
            a = $urandom;
            a[16:0] = 17'($urandom_range(0, 63));
            if (blk ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0))
                a = UART;
            else if ($urandom_range(0, 15) == 0)
                a = HWCNT;
            setreq($urandom_range(0, 1) == 1, 2'($urandom), 1'($urandom),
                   a, $urandom);
            bus.valid = $urandom_range(0, 3) != 0;
            @(posedge clk);
            #1;
        end
        idle();
        bus.uart_busy = 0;
        repeat (20) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
